// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encoding and glitch counter width for the debouncer
package debounce_pkg;
  localparam int GLITCH_W = 8;
  typedef enum logic [1:0] {S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT} state_t;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchronizer bringing an asynchronous level into clk
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_sync;
  // shift the raw level through the chain; only the first flop ever sees i_d
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end
  assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a bouncing input and accepts a level only after DEBOUNCE_CYCLES agreeing samples
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_raw,
  output logic                stable,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic [GLITCH_W-1:0] r_glitch, w_glitch, w_glitch_inc;
  logic                r_stable, w_stable, w_sync;
  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(d_raw),
    .o_q(w_sync)
  );
  assign w_glitch_inc = &r_glitch ? r_glitch : r_glitch + 1'b1;
  // next-state, sample counter, glitch tally and debounced level
  always_comb begin
    w_next   = r_state;
    w_cnt    = r_cnt;
    w_glitch = r_glitch;
    w_stable = r_stable;
    unique case (r_state)
      S_LOW: if (w_sync) begin
        w_next = S_RISE_WAIT;
        w_cnt  = CW'(1);
      end
      S_RISE_WAIT: if (!w_sync) begin
        w_next   = S_LOW;
        w_cnt    = '0;
        w_glitch = w_glitch_inc;
      end else if (r_cnt == CNT_MAX) begin
        w_next   = S_HIGH;
        w_cnt    = '0;
        w_stable = 1'b1;
      end else w_cnt = r_cnt + 1'b1;
      S_HIGH: if (!w_sync) begin
        w_next = S_FALL_WAIT;
        w_cnt  = CW'(1);
      end
      S_FALL_WAIT: if (w_sync) begin
        w_next   = S_HIGH;
        w_cnt    = '0;
        w_glitch = w_glitch_inc;
      end else if (r_cnt == CNT_MAX) begin
        w_next   = S_LOW;
        w_cnt    = '0;
        w_stable = 1'b0;
      end else w_cnt = r_cnt + 1'b1;
      default: begin
        w_next = S_LOW;
        w_cnt  = '0;
      end
    endcase
  end
  // state register; reset overrides any completing wait
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_LOW;
      r_cnt    <= '0;
      r_glitch <= '0;
      r_stable <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt;
      r_glitch <= w_glitch;
      r_stable <= w_stable;
    end
  end
  assign stable     = r_stable;
  assign busy       = (r_state == S_RISE_WAIT) || (r_state == S_FALL_WAIT);
  assign glitch_cnt = r_glitch;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed stimulus with a run-length reference model checked every cycle
module tb_button_debouncer;
  localparam int DC = 4;
  localparam int SS = 2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_raw = 1'b0;
  logic       stable, busy;
  logic [7:0] glitch_cnt;
  int total = 0;
  int bad = 0;
  bit m_pipe[SS];
  bit m_stable;
  int m_run;
  int m_glitch;
  bit armed = 1'b0;
  always #5 clk = ~clk;
  button_debouncer #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk(clk),
    .rst(rst),
    .d_raw(d_raw),
    .stable(stable),
    .busy(busy),
    .glitch_cnt(glitch_cnt)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  // reference: a level is accepted after DC consecutive delayed samples disagree with it
  always @(posedge clk) begin
    bit seen;
    if (rst) begin
      for (int i = 0; i < SS; i++) m_pipe[i] = 1'b0;
      m_stable = 1'b0;
      m_run    = 0;
      m_glitch = 0;
      armed    = 1'b1;
    end else begin
      seen = m_pipe[SS-1];
      for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = d_raw;
      if (seen != m_stable) begin
        m_run++;
        if (m_run == DC) begin
          m_stable = seen;
          m_run    = 0;
        end
      end else if (m_run > 0) begin
        m_run = 0;
        if (m_glitch < 255) m_glitch++;
      end
    end
  end
  // per-cycle comparison against the reference
  always @(negedge clk) begin
    if (armed) begin
      chk("model_stable", stable, m_stable);
      chk("model_busy", busy, m_run > 0);
      chk("model_glitch", glitch_cnt, m_glitch);
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stable", stable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_glitch", glitch_cnt, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    d_raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e >= 3 && e <= 5) chk("press_busy", busy, 1);
      if (e == 5) chk("press_stable_early", stable, 0);
      if (e == 6) begin
        chk("press_stable", stable, 1);
        chk("press_busy_done", busy, 0);
      end
    end
    chk("press_glitch", glitch_cnt, 0);
    d_raw = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 5) chk("release_stable_early", stable, 1);
      if (e == 6) chk("release_stable", stable, 0);
    end
    chk("release_glitch", glitch_cnt, 0);
    d_raw = 1'b1;
    repeat (2) @(negedge clk);
    d_raw = 1'b0;
    repeat (8) @(negedge clk);
    chk("bounce_stable", stable, 0);
    chk("bounce_busy", busy, 0);
    chk("bounce_glitch", glitch_cnt, 1);
    repeat (300) begin
      d_raw = 1'b1;
      @(negedge clk);
      d_raw = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("sat_glitch", glitch_cnt, 255);
    chk("sat_stable", stable, 0);
    d_raw = 1'b1;
    repeat (3) @(negedge clk);
    chk("midwait_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midwait_rst_stable", stable, 0);
    chk("midwait_rst_busy", busy, 0);
    chk("midwait_rst_glitch", glitch_cnt, 0);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 5) chk("after_rst_stable_early", stable, 0);
      if (e == 6) chk("after_rst_stable", stable, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
